spi_slave_fsm: RTL
==================

SPI_SLAVE_FSM -- requirements
Module: spi_slave_fsm

Interface
REQ-001 Parameter ADDR_SIZE, default 8, RAM address/data width; frame width is ADDR_SIZE+2.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SS_n  input  1  slave select, active-low; frame boundary.
REQ-005 MOSI  input  1  serial data in, sampled on rising clk, MSB first.
REQ-006 MISO  output  1  serial read data out, MSB first.
REQ-007 rx_data  output  ADDR_SIZE+2  assembled frame to the RAM; bits [ADDR_SIZE+1:ADDR_SIZE] are the command.
REQ-008 rx_valid  output  1  one-cycle strobe: rx_data is complete.
REQ-009 tx_data  input  ADDR_SIZE  read data returned by the RAM.
REQ-010 tx_valid  input  1  tx_data valid; sampled only in READ_DATA after that frame's rx_valid.

Function
REQ-011 States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA; encoding is an enum from the shared package.
REQ-012 IDLE -> CHK_CMD on the first edge SS_n is sampled 0; otherwise stay in IDLE.
REQ-013 CHK_CMD samples one selector bit on MOSI: 0 -> WRITE; 1 with rd_addr_flag=0 -> READ_ADD; 1 with rd_addr_flag=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA shift exactly ADDR_SIZE+2 MOSI bits, MSB first, into a shift register; a bit counter tracks progress.
REQ-015 The edge after the last bit is sampled: rx_data loads the shift register and rx_valid is 1 for exactly one cycle.
REQ-016 rx_data holds its value until the next rx_valid; the command bits are passed through and are not checked against the state.
REQ-017 rd_addr_flag sets on READ_ADD rx_valid and clears after the last MISO bit of READ_DATA.
REQ-018 READ_DATA, after rx_valid: wait for tx_valid=1 with no timeout, then load tx_data into the output shift register.
REQ-019 Starting the cycle after tx_valid is captured, drive MISO with ADDR_SIZE bits MSB first, one per clock.
REQ-020 MISO is 0 whenever not shifting read data.
REQ-021 After a completed frame, remain in the current state ignoring MOSI until SS_n is sampled 1.
REQ-022 SS_n sampled 1 in any state -> IDLE next edge; clear the bit counter and MISO.
REQ-023 SS_n abort before frame completion: no rx_valid, rd_addr_flag unchanged.
REQ-024 SS_n abort during the MISO shift: stop the shift and keep rd_addr_flag set.
REQ-025 tx_valid outside REQ-018's window is ignored.

Reset
REQ-026 rst_n=0 immediately forces state IDLE, rx_data 0, rx_valid 0, MISO 0, rd_addr_flag 0, and all counters and shift registers 0, regardless of clk.
REQ-027 First frame after reset release decodes normally; a reset mid-frame discards the partial frame.

Structure
REQ-028 ADDR_SIZE, MEM_DEPTH and the state enum typedef belong in RAM_shared_pkg, imported by this module and the RAM.
REQ-029 Single module, no sub-module; the module pairs with the RAM through rx_data/rx_valid/tx_data/tx_valid in the wrapper.

Verification (ADDR_SIZE=8)
REQ-030 Write address: SS_n low, selector 0, bits 00_1010_0101 -> rx_data=0x0A5, rx_valid high exactly one cycle, MISO 0 throughout.
REQ-031 Write data: selector 0, bits 01_0011_1100 -> rx_data=0x13C, one rx_valid pulse, rd_addr_flag stays 0.
REQ-032 Read address: selector 1 with flag 0, bits 10_0000_0101 -> READ_ADD, rx_data=0x205, rd_addr_flag=1 after the pulse.
REQ-033 Read data: selector 1 with flag 1, bits 11_0000_0000 -> rx_valid; tx_valid with tx_data=0xC3 -> MISO 1,1,0,0,0,0,1,1 on 8 consecutive cycles; rd_addr_flag=0.
REQ-034 Abort: SS_n high after 5 data bits -> no rx_valid, IDLE next edge; the following full write frame 00_1111_0000 gives rx_data=0x0F0.
REQ-035 rst_n low mid-MISO shift -> MISO, rx_valid and rd_addr_flag 0 without waiting for a clk edge; state IDLE.

Source files
------------

// File: rtl/RAM_shared_pkg.sv
// rtl/RAM_shared_pkg.sv - shared RAM/SPI widths and SPI slave state encoding
//
// Purpose: the constants and state type that the SPI slave and the RAM
// both import. Keeping them here lets the two ends agree on frame and
// address widths.
//   ADDR_SIZE : RAM address/data width; an SPI frame is ADDR_SIZE+2 bits
//   MEM_DEPTH : number of RAM words
//   state_e   : SPI slave FSM states
package RAM_shared_pkg;

  localparam int ADDR_SIZE = 8;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

endpackage

// File: rtl/spi_slave_fsm.sv
// rtl/spi_slave_fsm.sv - SPI slave frame decoder feeding a single-port RAM
//
// Purpose: the block receives ADDR_SIZE+2-bit frames on MOSI while SS_n is
// low and hands each complete frame to the RAM. A selector bit ahead of the
// frame picks the write path or the read path. The read path alternates
// between a read-address frame and a read-data frame. After a read-data
// frame the block returns the RAM word on MISO.
// Ports:
//   clk       - system clock, all logic on rising edge
//   rst_n     - asynchronous active-low reset
//   SS_n      - slave select, active-low, frames a transaction
//   MOSI      - serial data in, MSB first
//   MISO      - serial read data out, MSB first, 0 when idle
//   rx_data   - assembled frame, top two bits are the RAM command
//   rx_valid  - one-cycle strobe marking rx_data complete
//   tx_data   - read data returned by the RAM
//   tx_valid  - tx_data valid (only honoured while awaiting read data)
module spi_slave_fsm #(
  parameter int ADDR_SIZE = RAM_shared_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  import RAM_shared_pkg::*;

  localparam int FRAME_W  = ADDR_SIZE + 2;
  localparam int CNT_W    = $clog2(FRAME_W + 1);
  localparam int TX_CNT_W = $clog2(ADDR_SIZE + 1);

  state_e                 r_state;
  state_e                 w_state_next;

  logic [CNT_W-1:0]       r_bit_cnt;
  logic [FRAME_W-1:0]     r_shift;
  logic                   r_frame_done;   // rx_valid already issued this frame
  logic [ADDR_SIZE+1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_rd_addr_flag; // next read frame carries data, not address
  logic [ADDR_SIZE-1:0]   r_tx_sr;
  logic [TX_CNT_W-1:0]    r_tx_cnt;       // MISO bits still to follow the current one
  logic                   r_tx_busy;
  logic                   r_tx_done;      // read word already returned this frame
  logic                   r_miso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Deselect wins from every state. Once in a data state the FSM stays
  // there until deselect; frame completion is tracked in the datapath.
  always_comb begin
    w_state_next = r_state;
    if (SS_n) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI) begin
            w_state_next = WRITE;
          end else if (r_rd_addr_flag) begin
            w_state_next = READ_DATA;
          end else begin
            w_state_next = READ_ADD;
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_frame_done   <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_flag <= 1'b0;
      r_tx_sr        <= '0;
      r_tx_cnt       <= '0;
      r_tx_busy      <= 1'b0;
      r_tx_done      <= 1'b0;
      r_miso         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (SS_n) begin
        // Abort or end of transaction: drop partial progress. rx_data and
        // rd_addr_flag survive so an aborted read-data frame can be retried.
        r_bit_cnt    <= '0;
        r_shift      <= '0;
        r_frame_done <= 1'b0;
        r_tx_sr      <= '0;
        r_tx_cnt     <= '0;
        r_tx_busy    <= 1'b0;
        r_tx_done    <= 1'b0;
        r_miso       <= 1'b0;
      end else begin
        case (r_state)
          WRITE, READ_ADD, READ_DATA: begin
            if (r_bit_cnt != CNT_W'(FRAME_W)) begin
              r_shift   <= {r_shift[FRAME_W-2:0], MOSI};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (!r_frame_done) begin
              r_rx_data    <= r_shift;
              r_rx_valid   <= 1'b1;
              r_frame_done <= 1'b1;
              if (r_state == READ_ADD) begin
                r_rd_addr_flag <= 1'b1;
              end
            end else if (r_state == READ_DATA) begin
              if (r_tx_busy) begin
                if (r_tx_cnt != '0) begin
                  r_miso   <= r_tx_sr[ADDR_SIZE-1];
                  r_tx_sr  <= {r_tx_sr[ADDR_SIZE-2:0], 1'b0};
                  r_tx_cnt <= r_tx_cnt - 1'b1;
                end else begin
                  r_miso         <= 1'b0;
                  r_tx_busy      <= 1'b0;
                  r_tx_done      <= 1'b1;
                  r_rd_addr_flag <= 1'b0;
                end
              end else if (!r_tx_done && tx_valid) begin
                // The MSB goes straight to MISO; the rest queue in r_tx_sr.
                r_miso    <= tx_data[ADDR_SIZE-1];
                r_tx_sr   <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                r_tx_cnt  <= TX_CNT_W'(ADDR_SIZE - 1);
                r_tx_busy <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule
